mos_decoder_sweep_ctrl: RTL
===========================

// Module: mos_decoder_sweep_ctrl
// PURPOSE
//  Wishbone-programmed sequencer that drives the mos6502_decoder opcode input.
//  It sweeps an opcode range, waits a settle time per opcode, and folds each
//  66-bit decoded word into a 32-bit MISR signature.
//  Gives a post-silicon self-test of the decoder from the management SoC
//  without 256 individual bus read pairs.
// PARAMETERS
//  BASE_ADDR  32'h3000_0020  word-aligned base of this block's 6-register window
//  DEC_W      66             decoder result width
//  SETTLE_W   4              width of the per-opcode settle counter
//  MISR_POLY  32'h04C1_1DB7  MISR feedback polynomial
// PORTS
//  wb_clk_i              in   1      only clock
//  wb_rst_i              in   1      synchronous, active-high reset
//  wbs_stb_i             in   1      wishbone strobe
//  wbs_cyc_i             in   1      wishbone cycle
//  wbs_we_i              in   1      1 = write
//  wbs_adr_i             in   32     byte address
//  wbs_dat_i             in   32     write data
//  wbs_ack_o             out  1      one-cycle acknowledge
//  wbs_dat_o             out  32     read data, valid while ack is high
//  decoder_instruction_o out  8      opcode to the decoder
//  decoder_result_i      in   DEC_W  decoder output (combinational)
//  sweep_done_o          out  1      one-cycle pulse when a sweep completes
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   00 CTRL   W: bit0 start, bit1 abort (self-clearing, read 0)
//   04 STATUS R: bit0 busy, bit1 done, bit2 aborted
//   08 RANGE  RW: [7:0] first, [15:8] last
//   0C SETTLE RW: [SETTLE_W-1:0] settle S
//   10 SIG    R: MISR value
//   14 COUNT  R: [8:0] opcodes captured
//  Bus access:
//   - Access = stb & cyc & ~ack with adr inside [BASE, BASE+0x14].
//   - ack rises the next cycle and is high for exactly one cycle, even if stb stays high.
//   - Addresses outside the window are never acked.
//   - Unmapped or misaligned offsets inside the window: ack, read 32'h0, write ignored.
//   - wbs_dat_o is registered and holds its last value between reads.
//  Reset values:
//   - ack=0, dat_o=0, decoder_instruction_o=8'h00, sweep_done_o=0.
//   - RANGE=16'hFF00 (full sweep), S=0, SIG=32'hFFFF_FFFF, COUNT=0, STATUS=0, state IDLE.
//  FSM IDLE -> LOAD -> SETTLE -> CAPTURE -> (LOAD | IDLE):
//   - IDLE: a start write sets op=first, SIG=FFFF_FFFF, COUNT=0, busy=1, done=0,
//     aborted=0, then moves to LOAD.
//   - LOAD: decoder_instruction_o<=op, settle counter<=S.
//   - SETTLE: decrement the counter; leave when it reads 0, giving S+1 cycles in SETTLE.
//   - CAPTURE: f = r[31:0]^r[63:32]^{30'b0,r[65:64]};
//     SIG <= {SIG[30:0],1'b0} ^ (SIG[31] ? POLY : 0) ^ f; COUNT++.
//     If op==last: go to IDLE with busy=0, done=1 and pulse sweep_done_o.
//     Otherwise op<=op+1 (8-bit wrap) and go to LOAD.
//  Each opcode takes S+3 cycles.
//  first>last wraps through FF->00 and captures 256-first+last+1 opcodes.
//  first==last captures exactly 1 opcode; the maximum is 256, so COUNT is 9 bits.
//  While busy:
//   - start writes are ignored; RANGE/SETTLE writes are acked but ignored.
//   - SIG/COUNT reads return live values.
//  Abort from any non-IDLE state:
//   - go to IDLE next cycle with busy=0, aborted=1, done=0, no pulse.
//   - SIG/COUNT hold their partial values.
//   - Abort in IDLE is a no-op.
//  Start and abort in the same write: abort wins, no sweep is launched.
//  When idle, decoder_instruction_o holds the last opcode driven.
//  wb_rst_i mid-sweep returns everything to reset values on the next edge.
// STRUCTURE
//  Package mos_sweep_pkg:
//   - register offset localparams
//   - FSM state enum (IDLE, LOAD, SETTLE, CAPTURE)
//   - MISR_POLY
//   - fold function (66 -> 32 bits)
//  Sub-module mos_sig_misr: seed, enable, 66-bit input, 32-bit signature.
//  The FSM and bus register file live in this module.
// TESTING
//  Decoder is replaced by a stub returning all-zero.
//  1. Reset, read STATUS/RANGE/SIG -> 0, 16'hFF00, 32'hFFFF_FFFF; no ack outside
//     window (adr 32'h3000_0000).
//  2. RANGE=16'h0000, S=0, start -> done pulse 3 cycles after LOAD entry,
//     SIG=32'hFB3E_E249, COUNT=1, STATUS=3'b010.
//  3. Full sweep 00..FF, S=0 -> done pulse 768 cycles after leaving IDLE,
//     COUNT=256; opcode sequence 00..FF checked on decoder_instruction_o.
//  4. RANGE first=FE, last=01, S=2 -> opcodes FE,FF,00,01 each held 5 cycles,
//     COUNT=4.
//  5. Abort after 10 captures -> STATUS=3'b100, COUNT=10, no pulse;
//     start+abort in one write -> stays IDLE.
//  6. Start and RANGE write while busy ignored; stb held 3 cycles gives a single ack;
//     wb_rst_i mid-sweep restores all reset values.

Source files
------------

// File: rtl/mos_sweep_pkg.sv
// Shared definitions for the decoder sweep controller: register map, FSM states,
// MISR polynomial and the 66-to-32 bit fold applied to each decoded word.
package mos_sweep_pkg;

  // Byte offsets of the registers inside the 6-word window
  localparam logic [4:0] OfsCtrl   = 5'h00;
  localparam logic [4:0] OfsStatus = 5'h04;
  localparam logic [4:0] OfsRange  = 5'h08;
  localparam logic [4:0] OfsSettle = 5'h0C;
  localparam logic [4:0] OfsSig    = 5'h10;
  localparam logic [4:0] OfsCount  = 5'h14;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SigSeed   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSettle,
    StCapture
  } sweep_state_e;

  // Compress a 66-bit decoder word into 32 bits before it enters the MISR
  function automatic logic [31:0] fold66(input logic [65:0] r);
    return r[31:0] ^ r[63:32] ^ {30'b0, r[65:64]};
  endfunction

endpackage

// File: rtl/mos_sig_misr.sv
// 32-bit multiple-input signature register. seed_i restarts the signature,
// en_i folds one decoder word into it.
module mos_sig_misr
  import mos_sweep_pkg::*;
#(
  parameter logic [31:0] Poly = 32'h04C1_1DB7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        seed_i,
  input  logic        en_i,
  input  logic [65:0] data_i,
  output logic [31:0] sig_o
);

  logic [31:0] sig_q, sig_d;

  // Next signature: seed has priority over a capture
  always_comb begin
    sig_d = sig_q;
    if (seed_i) begin
      sig_d = SigSeed;
    end else if (en_i) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? Poly : 32'h0) ^ fold66(data_i);
    end
  end

  // Signature state, synchronous reset to the seed value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= SigSeed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/mos_decoder_sweep_ctrl.sv
// Wishbone-programmed opcode sweeper for the 6502 decoder: steps through an
// opcode range, lets each opcode settle, and compresses the decoded words into
// a MISR signature readable over the bus.
module mos_decoder_sweep_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0020,
  parameter int unsigned DEC_W     = 66,
  parameter int unsigned SETTLE_W  = 4,
  parameter logic [31:0] MISR_POLY = mos_sweep_pkg::MISR_POLY
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [7:0]       decoder_instruction_o,
  input  logic [DEC_W-1:0] decoder_result_i,
  output logic             sweep_done_o
);

  import mos_sweep_pkg::*;

  sweep_state_e        state_q;
  logic [7:0]          first_q, last_q, op_q;
  logic [SETTLE_W-1:0] settle_q, cnt_q;
  logic [8:0]          count_q;
  logic                done_q, aborted_q;
  // Set once a strobe has been served, so a held strobe gets a single ack
  logic                served_q;

  logic        in_window, bus_access, aligned, wr_access, ctrl_wr;
  logic        start_req, abort_req, launch, do_abort, capture_en, busy;
  logic [4:0]  ofs;
  logic [31:0] rd_data;
  logic [31:0] sig;
  logic        unused_dat;

  assign unused_dat = ^wbs_dat_i[31:16];

  // Bus decode
  assign in_window  = (wbs_adr_i >= BASE_ADDR) && (wbs_adr_i <= BASE_ADDR + 32'h14);
  assign ofs        = wbs_adr_i[4:0] - BASE_ADDR[4:0];
  assign aligned    = (ofs[1:0] == 2'b00);
  assign bus_access = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & ~served_q & in_window;
  assign wr_access  = bus_access & wbs_we_i & aligned;
  assign ctrl_wr    = wr_access && (ofs == OfsCtrl);
  assign start_req  = ctrl_wr & wbs_dat_i[0];
  assign abort_req  = ctrl_wr & wbs_dat_i[1];

  assign busy       = (state_q != StIdle);
  // Abort beats start when both arrive in one write
  assign launch     = ~busy & start_req & ~abort_req;
  assign do_abort   = busy & abort_req;
  assign capture_en = (state_q == StCapture) & ~do_abort;

  mos_sig_misr #(
    .Poly(MISR_POLY)
  ) u_misr (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .seed_i(launch),
    .en_i  (capture_en),
    .data_i(decoder_result_i),
    .sig_o (sig)
  );

  // Read data mux; misaligned or unmapped offsets read as zero
  always_comb begin
    rd_data = 32'h0;
    if (aligned) begin
      case (ofs)
        OfsStatus: rd_data = {29'b0, aborted_q, done_q, busy};
        OfsRange:  rd_data = {16'b0, last_q, first_q};
        OfsSettle: rd_data = {{(32 - SETTLE_W){1'b0}}, settle_q};
        OfsSig:    rd_data = sig;
        OfsCount:  rd_data = {23'b0, count_q};
        default:   rd_data = 32'h0;
      endcase
    end
  end

  // Bus handshake, register file and sweep FSM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o             <= 1'b0;
      wbs_dat_o             <= 32'h0;
      served_q              <= 1'b0;
      decoder_instruction_o <= 8'h00;
      sweep_done_o          <= 1'b0;
      first_q               <= 8'h00;
      last_q                <= 8'hFF;
      settle_q              <= '0;
      cnt_q                 <= '0;
      op_q                  <= 8'h00;
      count_q               <= 9'd0;
      done_q                <= 1'b0;
      aborted_q             <= 1'b0;
      state_q               <= StIdle;
    end else begin
      wbs_ack_o    <= bus_access;
      sweep_done_o <= 1'b0;

      if (bus_access) begin
        served_q <= 1'b1;
      end else if (!(wbs_stb_i && wbs_cyc_i)) begin
        served_q <= 1'b0;
      end

      if (bus_access && !wbs_we_i) begin
        wbs_dat_o <= rd_data;
      end

      // Configuration is frozen while a sweep runs
      if (wr_access && !busy) begin
        if (ofs == OfsRange) begin
          first_q <= wbs_dat_i[7:0];
          last_q  <= wbs_dat_i[15:8];
        end
        if (ofs == OfsSettle) begin
          settle_q <= wbs_dat_i[SETTLE_W-1:0];
        end
      end

      if (do_abort) begin
        state_q   <= StIdle;
        aborted_q <= 1'b1;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (launch) begin
              op_q      <= first_q;
              count_q   <= 9'd0;
              done_q    <= 1'b0;
              aborted_q <= 1'b0;
              state_q   <= StLoad;
            end
          end
          StLoad: begin
            decoder_instruction_o <= op_q;
            cnt_q                 <= settle_q;
            state_q               <= StSettle;
          end
          StSettle: begin
            if (cnt_q == '0) begin
              state_q <= StCapture;
            end else begin
              cnt_q <= cnt_q - SETTLE_W'(1);
            end
          end
          StCapture: begin
            count_q <= count_q + 9'd1;
            if (op_q == last_q) begin
              state_q      <= StIdle;
              done_q       <= 1'b1;
              sweep_done_o <= 1'b1;
            end else begin
              op_q    <= op_q + 8'd1;
              state_q <= StLoad;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
